// File: rtl/sig_debounce.sv
// Synchronise a bouncy asynchronous input and accept a level change only after it
// holds for STABLE_CYCLES cycles. Define SIG_DEBOUNCE_GLITCH_CNT_EN to add glitchCnt.
module sig_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rawIn,
    output logic       dataOut,
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    output logic [7:0] glitchCnt,
`endif
    output logic       busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_in;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_data_out;
    logic                   r_busy;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]             r_glitch_cnt;
`endif

    // NOTE: every flop here, synchroniser included, takes the async reset so the
    // post-reset view of rawIn is a known 0 and a high input is seen as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rawIn};
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

    // NOTE: all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others, whatever order the statements are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= STABLE_LO;
            r_cnt        <= '0;
            r_data_out   <= 1'b0;
            r_busy       <= 1'b0;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
            r_glitch_cnt <= 8'd0;
`endif
        end else begin
            case (r_state)
                STABLE_LO: begin
                    if (w_sync_in) begin
                        if (STABLE_CYCLES == 1) begin
                            r_state    <= STABLE_HI;
                            r_data_out <= 1'b1;
                        end else begin
                            r_state <= CHECK_HI;
                            r_cnt   <= CNT_W'(1);
                            r_busy  <= 1'b1;
                        end
                    end
                end

                CHECK_HI: begin
                    if (!w_sync_in) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
                        if (r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= STABLE_HI;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_data_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STABLE_HI: begin
                    if (!w_sync_in) begin
                        if (STABLE_CYCLES == 1) begin
                            r_state    <= STABLE_LO;
                            r_data_out <= 1'b0;
                        end else begin
                            r_state <= CHECK_LO;
                            r_cnt   <= CNT_W'(1);
                            r_busy  <= 1'b1;
                        end
                    end
                end

                CHECK_LO: begin
                    if (w_sync_in) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
                        if (r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
`endif
                    end else if (r_cnt == CNT_LAST) begin
                        r_state    <= STABLE_LO;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_data_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= STABLE_LO;
                    r_cnt      <= '0;
                    r_busy     <= 1'b0;
                    r_data_out <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut = r_data_out;
    assign busy    = r_busy;
`ifdef SIG_DEBOUNCE_GLITCH_CNT_EN
    assign glitchCnt = r_glitch_cnt;
`endif

endmodule
